// File: rtl/bus_memory_responder_if.sv
// Request/handshake signals between the datapath control unit and the data-memory responder.
// The 64-bit tristate data bus stays a plain inout on the responder so it can be resolved at the top level.
interface bus_memory_responder_if;
    logic [31:0] address;
    logic        MR;
    logic        MW;
    logic        ready;
    logic        err;
    logic        busy;

    // Handshake: MR/MW are levels held by the master until ready is seen.
    // ready is a one-cycle strobe. err qualifies ready and means nothing while ready=0.
    // After ready, the responder waits until MR and MW are both low before it accepts again.
    modport slave (
        input  address,
        input  MR,
        input  MW,
        output ready,
        output err,
        output busy
    );

    modport master (
        output address,
        output MR,
        output MW,
        input  ready,
        input  err,
        input  busy
    );
endinterface

// File: rtl/bus_memory_responder.sv
// Windowed 64-bit data-memory responder with wait states and a ready/err handshake on a shared tristate bus.
// Optional macro BUS_MEM_ALIGN_CHECK_EN turns accesses with address[2:0] != 0 into err responses.
module bus_memory_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH_LOG2  = 8,
    parameter int          WAIT_STATES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    inout  wire  [63:0]             data,
    bus_memory_responder_if.slave   bus,
    output logic [1:0]              state_o,
    output logic                    drive_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESP    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_ERR = 2'd2
    } op_t;

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI    = WIN_LO + (33'd8 << DEPTH_LOG2);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                  state_q, state_d;
    op_t                     op_q, op_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [63:0]             wdata_q, wdata_d;
    logic [63:0]             rdata_q;
    logic                    ready_q;
    logic                    err_q;
    logic                    drive_q;

    logic [63:0]             mem [DEPTH];

    logic                    hit;
    logic                    req;
    logic                    misalign;
    logic                    resp_enter;
    logic                    mem_we;
    logic                    mem_re;

    // 33-bit compare so a window touching the top of the address space cannot wrap.
    always_comb begin
        hit = ({1'b0, bus.address} >= WIN_LO) && ({1'b0, bus.address} < WIN_HI);
        req = bus.MR || bus.MW;
`ifdef BUS_MEM_ALIGN_CHECK_EN
        misalign = |bus.address[2:0];
`else
        misalign = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                // A miss leaves the bus alone: another responder may own this address.
                if (hit && req) begin
                    idx_d   = bus.address[DEPTH_LOG2+2:3];
                    wdata_d = data;
                    if ((bus.MR && bus.MW) || misalign) begin
                        op_d = OP_ERR;
                    end else if (bus.MW) begin
                        op_d = OP_WR;
                    end else begin
                        op_d = OP_RD;
                    end
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Holding here until both requests drop keeps a held level from being served twice.
                if (!bus.MR && !bus.MW) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The memory is touched only on the edge that enters RESP; idx_d/op_d cover the zero-wait case.
    always_comb begin
        resp_enter = (state_d == S_RESP) && (state_q != S_RESP);
        mem_we     = resp_enter && (op_d == OP_WR) && reset;
        mem_re     = resp_enter && (op_d == OP_RD);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_RD;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            if (mem_re) begin
                rdata_q <= mem[idx_d];
            end
            // Strobes are registered from the RESP state, so the ready cycle is one edge after RESP.
            ready_q <= (state_q == S_RESP);
            err_q   <= (state_q == S_RESP) && (op_q == OP_ERR);
            drive_q <= (state_q == S_RESP) && (op_q == OP_RD);
        end
    end

    // Array contents deliberately have no reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx_d] <= wdata_d;
        end
    end

    assign data      = drive_q ? rdata_q : 64'bz;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign state_o   = state_q;
    assign drive_o   = drive_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Scoreboard bench for bus_memory_responder: expectations are queued at request time and popped on ready.
// Builds with or without BUS_MEM_ALIGN_CHECK_EN; the misaligned-access expectation follows the macro.
module tb_bus_memory_responder;

    localparam logic [31:0] BASE_ADDR   = 32'h0000_1000;
    localparam int          DEPTH_LOG2  = 8;
    localparam int          WAIT_STATES = 2;
    localparam int          W           = 66;

    logic        clock;
    logic        reset;
    wire  [63:0] data;
    logic        tb_drv;
    logic [63:0] tb_wdata;
    logic [1:0]  state_o;
    logic        drive_o;

    bus_memory_responder_if bus_if ();

    assign data = tb_drv ? tb_wdata : 64'bz;

    bus_memory_responder #(
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .WAIT_STATES (WAIT_STATES)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .data    (data),
        .bus     (bus_if),
        .state_o (state_o),
        .drive_o (drive_o)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard state: {is_read, err, read_data}
    logic [W-1:0] exp_q[$];
    logic [63:0]  model_mem [256];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        logic [W-1:0] e;
        if (reset && bus_if.ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_ready", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("err", {63'd0, bus_if.err}, {63'd0, e[64]});
                check_eq("drive", {63'd0, drive_o}, {63'd0, e[65]});
                if (e[65]) check_eq("rdata", data, e[63:0]);
            end
        end
    end

    // Driver: queue the expected response and present the request.
    task automatic push_and_drive(input logic [31:0] addr, input logic mr, input logic mw,
                                  input logic [63:0] wd);
        logic         is_err;
        logic [7:0]   idx;
        logic [W-1:0] e;
        idx    = addr[10:3];
        is_err = mr && mw;
`ifdef BUS_MEM_ALIGN_CHECK_EN
        if (addr[2:0] != 3'd0) is_err = 1'b1;
`endif
        if (is_err) begin
            e = {1'b0, 1'b1, 64'd0};
        end else if (mw) begin
            e = {1'b0, 1'b0, 64'd0};
            model_mem[idx] = wd;
        end else begin
            e = {1'b1, 1'b0, model_mem[idx]};
        end
        exp_q.push_back(e);
        bus_if.address = addr;
        bus_if.MR      = mr;
        bus_if.MW      = mw;
        tb_wdata       = wd;
        tb_drv         = mw;
    endtask

    // Full access: request, bounded wait for ready, release, check return to IDLE.
    task automatic access(input logic [31:0] addr, input logic mr, input logic mw, input logic [63:0] wd);
        int   lat;
        logic z_ok;
        @(negedge clock);
        push_and_drive(addr, mr, mw, wd);
        lat  = 0;
        z_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (bus_if.ready) begin
                lat = c;
                break;
            end
            if (drive_o) z_ok = 1'b0;
        end
        // First negedge is in the cycle after the acceptance edge k; ready is due after edge k+WS+1.
        check_eq("latency", 64'(lat), 64'(WAIT_STATES + 2));
        check_eq("z_before_ready", {63'd0, z_ok}, 64'd1);
        check_eq("busy_in_ready", {63'd0, bus_if.busy}, 64'd1);
        bus_if.MR = 1'b0;
        bus_if.MW = 1'b0;
        tb_drv    = 1'b0;
        @(negedge clock);
        check_eq("ready_one_cycle", {63'd0, bus_if.ready}, 64'd0);
        check_eq("z_after_ready", {63'd0, drive_o}, 64'd0);
        @(negedge clock);
        check_eq("idle_after_release", {63'd0, bus_if.busy}, 64'd0);
    endtask

    task automatic out_of_window(input logic [31:0] addr);
        logic quiet;
        @(negedge clock);
        bus_if.address = addr;
        bus_if.MR      = 1'b1;
        bus_if.MW      = 1'b0;
        quiet          = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus_if.ready || drive_o || bus_if.busy) quiet = 1'b0;
        end
        check_eq("miss_quiet", {63'd0, quiet}, 64'd1);
        bus_if.MR = 1'b0;
    endtask

    initial begin
        int   pulses;
        logic busy_ok;
        logic seen;
        logic [7:0] widx [6];

        reset          = 1'b0;
        tb_drv         = 1'b0;
        tb_wdata       = 64'd0;
        bus_if.address = 32'd0;
        bus_if.MR      = 1'b0;
        bus_if.MW      = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_ready", {63'd0, bus_if.ready}, 64'd0);
        check_eq("rst_err", {63'd0, bus_if.err}, 64'd0);
        check_eq("rst_busy", {63'd0, bus_if.busy}, 64'd0);
        check_eq("rst_state", {62'd0, state_o}, 64'd0);
        check_eq("rst_drive", {63'd0, drive_o}, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Directed write/read pairs, including the last doubleword of the window.
        access(32'h0000_1000, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
        access(32'h0000_1008, 1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        access(32'h0000_1008, 1'b1, 1'b0, 64'd0);
        access(32'h0000_17F8, 1'b0, 1'b1, 64'h5555_AAAA_0F0F_F0F0);
        access(32'h0000_17F8, 1'b1, 1'b0, 64'd0);

        // Both requests high: err response, memory untouched.
        access(32'h0000_1000, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        access(32'h0000_1000, 1'b1, 1'b0, 64'd0);

        // Misaligned read of the first doubleword.
        access(32'h0000_1004, 1'b1, 1'b0, 64'd0);

        // Window boundaries just outside on both sides.
        out_of_window(32'h0000_0FF8);
        out_of_window(32'h0000_1800);

        // Reset during the second WAIT cycle of a write must not commit it.
        access(32'h0000_1010, 1'b0, 1'b1, 64'h1111_2222_3333_4444);
        @(negedge clock);
        bus_if.address = 32'h0000_1010;
        bus_if.MW      = 1'b1;
        tb_wdata       = 64'h9999_8888_7777_6666;
        tb_drv         = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_eq("wait_before_reset", {62'd0, state_o}, 64'd1);
        reset = 1'b0;
        #1;
        check_eq("reset_ready", {63'd0, bus_if.ready}, 64'd0);
        check_eq("reset_busy", {63'd0, bus_if.busy}, 64'd0);
        bus_if.MW = 1'b0;
        tb_drv    = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        access(32'h0000_1010, 1'b1, 1'b0, 64'd0);

        // Held read: one ready only, busy stays high in RELEASE.
        @(negedge clock);
        push_and_drive(32'h0000_1000, 1'b1, 1'b0, 64'd0);
        pulses  = 0;
        busy_ok = 1'b1;
        seen    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (bus_if.ready) begin
                pulses++;
                seen = 1'b1;
            end else if (seen && !bus_if.busy) begin
                busy_ok = 1'b0;
            end
        end
        check_eq("held_pulses", 64'(pulses), 64'd1);
        check_eq("held_busy", {63'd0, busy_ok}, 64'd1);
        bus_if.MR = 1'b0;
        @(negedge clock);
        push_and_drive(32'h0000_1000, 1'b1, 1'b0, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus_if.ready) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("held_second_ready", {63'd0, seen}, 64'd1);
        bus_if.MR = 1'b0;
        repeat (2) @(negedge clock);

        // Random aligned writes, then read them back.
        for (int i = 0; i < 6; i++) begin
            widx[i] = 8'($urandom_range(0, 255));
            access(BASE_ADDR + {21'd0, widx[i], 3'd0}, 1'b0, 1'b1, {$urandom, $urandom});
        end
        for (int i = 5; i >= 0; i--) begin
            access(BASE_ADDR + {21'd0, widx[i], 3'd0}, 1'b1, 1'b0, 64'd0);
        end

        repeat (3) @(negedge clock);
        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
